imem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported synchronous instruction memory between the core's fetch stage and the debug/program-loader port. Fetch has fixed priority. A starvation counter guarantees the loader a slot after a bounded wait. A lock input lets the loader hold fetch off while it rewrites program memory. The block sits between the fetch stage / UART loader and the instruction RAM, and routes each read response back to the port that issued it.

---
 rtl/imem_arbiter.sv | 104 ++++++++++
 tb/tb_imem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Shares the single-ported instruction RAM between core fetch (fixed priority) and the debug/loader port.
// A starvation counter bounds the debug wait; d_lock holds fetch off during program loads.
module imem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 7,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [31:0]           f_rdata,
    output logic                  f_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic                  d_lock,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DEBUG} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    owner_t     resp_owner;
    logic       resp_we;
    logic       resp_err;
    logic       starved;

    assign starved = (starve_cnt == LIMIT);

    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (d_lock) begin
            d_gnt = d_req;
        end else if (starved && d_req) begin
            d_gnt = 1'b1;
        end else begin
            f_gnt = f_req;
            d_gnt = d_req && !f_req;
        end
    end

    // Address/data are forced to zero when idle so the RAM bus is quiet.
    always_comb begin
        mem_en    = f_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt)
            mem_addr = d_addr[DEPTH_LOG2+1:2];
        else if (f_gnt)
            mem_addr = f_addr[DEPTH_LOG2+1:2];
        if (mem_en)
            mem_wdata = d_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (d_req && !d_gnt) begin
            if (!starved)
                starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_owner <= OWN_NONE;
            resp_we    <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            resp_owner <= f_gnt ? OWN_FETCH : (d_gnt ? OWN_DEBUG : OWN_NONE);
            resp_we    <= d_gnt && d_we;
            resp_err   <= f_gnt && (f_addr[1:0] != 2'b00);
        end
    end

    assign f_rvalid = (resp_owner == OWN_FETCH);
    assign f_rdata  = f_rvalid ? mem_rdata : 32'd0;
    assign f_err    = f_rvalid && resp_err;
    assign d_rvalid = (resp_owner == OWN_DEBUG);
    assign d_rdata  = (d_rvalid && !resp_we) ? mem_rdata : 32'd0;

    // Word-offset and out-of-range address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], f_addr[1:0],
                                d_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], d_addr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: behavioural RAM, a spec-level model checked every cycle,
// and literal expectations for each test-plan scenario.
module tb_imem_arbiter;
    localparam int AW = 32;
    localparam int DL = 7;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          f_req, d_req, d_we, d_lock;
    logic [AW-1:0] f_addr, d_addr;
    logic [31:0]   d_wdata;
    logic          f_gnt, f_rvalid, f_err, d_gnt, d_rvalid;
    logic [31:0]   f_rdata, d_rdata;
    logic          mem_en, mem_we;
    logic [DL-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;

    int nvec = 0;
    int nerr = 0;

    imem_arbiter #(.ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Write-first synchronous RAM, word i preloaded with 0xA0000000|i.
    logic [31:0] ram [128];
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 128; i++) ram[i] <= 32'hA000_0000 | 32'(i);
            ram_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model state: pending response (0 none, 1 fetch, 2 debug), cycles debug has been refused, RAM image.
    int          m_own = 0;
    logic [31:0] m_data = 32'd0;
    logic        m_err = 1'b0;
    int          m_wait = 0;
    logic [31:0] mm [128];
    logic        mm_init = 1'b0;
    logic        eg, ed;
    int          fw, dw, ew;

    always @(negedge clk) begin
        if (!mm_init) begin
            for (int i = 0; i < 128; i++) mm[i] = 32'hA000_0000 | 32'(i);
            mm_init = 1'b1;
        end
        if (!reset_n) begin
            m_own  = 0;
            m_wait = 0;
        end
        chk("f_rvalid", {31'd0, f_rvalid}, {31'd0, m_own == 1});
        chk("f_rdata", f_rdata, (m_own == 1) ? m_data : 32'd0);
        chk("f_err", {31'd0, f_err}, {31'd0, (m_own == 1) && m_err});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, m_own == 2});
        chk("d_rdata", d_rdata, (m_own == 2) ? m_data : 32'd0);

        if (d_lock) begin
            eg = 1'b0; ed = d_req;
        end else if (d_req && m_wait >= SL) begin
            eg = 1'b0; ed = 1'b1;
        end else begin
            eg = f_req; ed = d_req && !f_req;
        end
        fw = int'(f_addr / 4) % 128;
        dw = int'(d_addr / 4) % 128;
        ew = ed ? dw : (eg ? fw : 0);
        chk("f_gnt", {31'd0, f_gnt}, {31'd0, eg});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, ed});
        chk("mem_en", {31'd0, mem_en}, {31'd0, eg || ed});
        chk("mem_we", {31'd0, mem_we}, {31'd0, ed && d_we});
        chk("mem_addr", 32'(mem_addr), 32'(ew));
        if (!(eg || ed)) chk("mem_wdata_idle", mem_wdata, 32'd0);
        if (ed && d_we)  chk("mem_wdata", mem_wdata, d_wdata);

        if (reset_n) begin
            m_own  = eg ? 1 : (ed ? 2 : 0);
            m_err  = eg && (f_addr % 4 != 0);
            m_data = ed ? (d_we ? 32'd0 : mm[dw]) : (eg ? mm[fw] : 32'd0);
            m_wait = (d_req && !ed) ? ((m_wait < SL) ? m_wait + 1 : SL) : 0;
        end
        if (ed && d_we) mm[dw] = d_wdata;
    end

    task automatic set(input logic f, input logic [31:0] fa, input logic d, input logic we,
                       input logic [31:0] da, input logic [31:0] wd, input logic lk);
        f_req = f; f_addr = fa; d_req = d; d_we = we; d_addr = da; d_wdata = wd; d_lock = lk;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        set(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        tick;

        // fetch-only stream
        set(1, 32'h0, 0, 0, 0, 0, 0); @(negedge clk); chk("fs_gnt", {31'd0, f_gnt}, 32'd1); tick;
        set(1, 32'h4, 0, 0, 0, 0, 0); @(negedge clk); chk("fs_w0", f_rdata, 32'hA000_0000); tick;
        set(1, 32'h8, 0, 0, 0, 0, 0); @(negedge clk); chk("fs_w1", f_rdata, 32'hA000_0001); tick;
        set(0, 0, 0, 0, 0, 0, 0);     @(negedge clk); chk("fs_w2", f_rdata, 32'hA000_0002);
        chk("fs_no_d", {31'd0, d_rvalid}, 32'd0); tick;

        // starvation: debug granted on cycle SL+1
        for (int c = 1; c <= 5; c++) begin
            set(1, 32'h10, 1, 0, 32'h3C, 0, 0);
            @(negedge clk);
            chk("st_dgnt", {31'd0, d_gnt}, {31'd0, c == 5});
            chk("st_fgnt", {31'd0, f_gnt}, {31'd0, c != 5});
            tick;
        end
        set(1, 32'h10, 1, 0, 32'h3C, 0, 0); @(negedge clk);
        chk("st_rdata", d_rdata, 32'hA000_000F);
        chk("st_cnt_clr", {31'd0, d_gnt}, 32'd0); tick;

        // program load under lock
        set(1, 32'h0, 1, 1, 32'h0, 32'h0050_0113, 1); @(negedge clk);
        chk("lk_fgnt", {31'd0, f_gnt}, 32'd0); chk("lk_we", {31'd0, mem_we}, 32'd1); tick;
        set(1, 32'h0, 1, 0, 32'h0, 0, 1); @(negedge clk);
        chk("lk_ack", {31'd0, d_rvalid}, 32'd1); chk("lk_ack0", d_rdata, 32'd0); tick;
        set(1, 32'h0, 0, 0, 0, 0, 1); @(negedge clk);
        chk("lk_rd", d_rdata, 32'h0050_0113); chk("lk_fgnt2", {31'd0, f_gnt}, 32'd0); tick;
        set(1, 32'h0, 0, 0, 0, 0, 0); @(negedge clk); tick;
        set(0, 0, 0, 0, 0, 0, 0); @(negedge clk); chk("lk_fetch", f_rdata, 32'h0050_0113); tick;

        // lock rises mid-stream
        set(1, 32'h20, 0, 0, 0, 0, 0); @(negedge clk); chk("ms_gnt", {31'd0, f_gnt}, 32'd1); tick;
        set(1, 32'h24, 0, 0, 0, 0, 1); @(negedge clk);
        chk("ms_nogntA", {31'd0, f_gnt}, 32'd0); chk("ms_rdata", f_rdata, 32'hA000_0008); tick;
        @(negedge clk);
        chk("ms_nogntB", {31'd0, f_gnt}, 32'd0); chk("ms_norv", {31'd0, f_rvalid}, 32'd0); tick;

        // misaligned + wrapped fetch
        set(1, 32'h206, 0, 0, 0, 0, 0); @(negedge clk); chk("mis_addr", 32'(mem_addr), 32'd1); tick;
        set(0, 0, 0, 0, 0, 0, 0); @(negedge clk);
        chk("mis_err", {31'd0, f_err}, 32'd1); chk("mis_data", f_rdata, 32'hA000_0001); tick;

        // reset in the cycle after a debug read is accepted
        set(0, 0, 1, 0, 32'h8, 0, 0); @(negedge clk); chk("rr_gnt", {31'd0, d_gnt}, 32'd1); tick;
        set(1, 32'h10, 1, 0, 32'h8, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rr_drv", {31'd0, d_rvalid}, 32'd0); chk("rr_drd", d_rdata, 32'd0);
        tick; @(negedge clk); tick;
        reset_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("rr_starve", {31'd0, d_gnt}, {31'd0, c == 5});
            tick;
        end
        set(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
